// File: rtl/bicubic_acc_pkg.sv
// Shared widths and DSP accumulator mode encoding for the bicubic accumulator sequencer.
package bicubic_acc_pkg;
  localparam int DSP_OP_W  = 18;
  localparam int DSP_ACC_W = 48;

  typedef enum logic {ACC_MODE_LOAD = 1'b0, ACC_MODE_ADD = 1'b1} acc_mode_e;
endpackage

// File: rtl/bicubic_acc_sequencer_if.sv
// Beat stream in, DSP array drive/return, and pixel stream out of the accumulator sequencer.
interface bicubic_acc_sequencer_if #(parameter int PARALLEL_CORE = 4);
  import bicubic_acc_pkg::*;

  logic                                    s_valid;
  logic                                    s_ready;
  logic                                    s_first;
  logic [PARALLEL_CORE-1:0][DSP_OP_W-1:0]  s_op0, s_op1, s_op2, s_op3;
  logic [PARALLEL_CORE-1:0]                s_cin2, s_cin3;

  logic                                    dsp_clken;
  logic                                    dsp_reset;
  acc_mode_e                               dsp_mode;
  logic [PARALLEL_CORE-1:0][DSP_OP_W-1:0]  dsp_op0, dsp_op1, dsp_op2, dsp_op3;
  logic [PARALLEL_CORE-1:0]                dsp_cin2, dsp_cin3;
  logic [PARALLEL_CORE-1:0][DSP_ACC_W-1:0] dsp_result;

  logic                                    m_valid;
  logic                                    m_ready;
  logic [PARALLEL_CORE-1:0][DSP_ACC_W-1:0] m_data;

  // master: the sequencer; slave: beat source, DSP array and pixel sink.
  modport master (
    input  s_valid, s_first, s_op0, s_op1, s_op2, s_op3, s_cin2, s_cin3,
    input  dsp_result, m_ready,
    output s_ready, dsp_clken, dsp_reset, dsp_mode,
    output dsp_op0, dsp_op1, dsp_op2, dsp_op3, dsp_cin2, dsp_cin3,
    output m_valid, m_data
  );
  modport slave (
    output s_valid, s_first, s_op0, s_op1, s_op2, s_op3, s_cin2, s_cin3,
    output dsp_result, m_ready,
    input  s_ready, dsp_clken, dsp_reset, dsp_mode,
    input  dsp_op0, dsp_op1, dsp_op2, dsp_op3, dsp_cin2, dsp_cin3,
    input  m_valid, m_data
  );
endinterface

// File: rtl/bicubic_acc_tag_pipe.sv
// Group-done flag shifter matching the DSP latency; advances with the DSP clock enable.
module bicubic_acc_tag_pipe #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  input  logic tag_in,
  output logic tag_out,
  output logic busy
);
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= tag_in;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tag_out = vld_pipe[STAGES];
  assign busy    = |vld_pipe;
endmodule

// File: rtl/bicubic_acc_sequencer.sv
// Groups 4-operand beats into pixels on the DSP accumulator array and returns each
// finished per-lane sum on a backpressured output register.
module bicubic_acc_sequencer
  import bicubic_acc_pkg::*;
#(
  parameter int PARALLEL_CORE   = 4,
  parameter int BEATS_PER_PIXEL = 4,
  parameter int DSP_LATENCY     = 3
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    flush,
  bicubic_acc_sequencer_if.master bus,
  output logic                    busy,
  output logic                    err_sync
);
  localparam int               CNT_W  = $clog2(BEATS_PER_PIXEL + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BEATS_PER_PIXEL - 1);

  logic [CNT_W-1:0] beat_cnt, beat_k;
  logic             stall, accept, restart, is_last;
  logic             dsp_rst_q, tag_out, tags_busy, m_valid_q;
  logic [PARALLEL_CORE-1:0][DSP_ACC_W-1:0] m_data_q;

  // Freezing the whole DSP array on backpressure keeps results aligned with their tags.
  assign stall   = m_valid_q & ~bus.m_ready;
  assign accept  = bus.s_valid & bus.s_ready;
  // s_first resyncs: a marked beat always loads, abandoning any partial group.
  assign beat_k  = bus.s_first ? '0 : beat_cnt;
  assign restart = accept & bus.s_first & (beat_cnt != '0);
  assign is_last = accept & (beat_k == LAST_K);

  assign bus.dsp_clken = ~stall;
  assign bus.s_ready   = ~stall & ~dsp_rst_q & ~flush;
  assign bus.dsp_reset = dsp_rst_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign busy          = (beat_cnt != '0) | tags_busy | m_valid_q;

  // Bubbles feed zeros in ADD mode so the accumulators hold their value.
  always_comb begin
    bus.dsp_op0  = '0;
    bus.dsp_op1  = '0;
    bus.dsp_op2  = '0;
    bus.dsp_op3  = '0;
    bus.dsp_cin2 = '0;
    bus.dsp_cin3 = '0;
    bus.dsp_mode = dsp_rst_q ? ACC_MODE_LOAD : ACC_MODE_ADD;
    if (accept) begin
      bus.dsp_op0  = bus.s_op0;
      bus.dsp_op1  = bus.s_op1;
      bus.dsp_op2  = bus.s_op2;
      bus.dsp_op3  = bus.s_op3;
      bus.dsp_cin2 = bus.s_cin2;
      bus.dsp_cin3 = bus.s_cin3;
      bus.dsp_mode = (beat_k == '0) ? ACC_MODE_LOAD : ACC_MODE_ADD;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      err_sync  <= 1'b0;
      dsp_rst_q <= 1'b1;
    end else begin
      dsp_rst_q <= flush;
      if (flush) begin
        beat_cnt <= '0;
        err_sync <= 1'b0;
      end else begin
        if (accept) beat_cnt <= is_last ? '0 : beat_k + 1'b1;
        if (restart) err_sync <= 1'b1;
      end
    end
  end

  bicubic_acc_tag_pipe #(.STAGES(DSP_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (flush),
    .en      (bus.dsp_clken),
    .tag_in  (is_last),
    .tag_out (tag_out),
    .busy    (tags_busy)
  );

  // A tag exiting in the same cycle the sink takes the current pixel reloads the register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (flush) begin
      m_valid_q <= 1'b0;
    end else if (tag_out & bus.dsp_clken) begin
      m_valid_q <= 1'b1;
      m_data_q  <= bus.dsp_result;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bicubic_acc_sequencer.sv
// Directed bench: DSP array model (latency 3) plus per-lane tap-sum scoreboard.
module tb_bicubic_acc_sequencer;
  import bicubic_acc_pkg::*;

  localparam int N   = 4;
  localparam int BPP = 4;
  localparam int LAT = 3;

  typedef logic [N-1:0][DSP_ACC_W-1:0] pix_t;
  typedef logic [N-1:0][DSP_OP_W-1:0]  ops_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic flush = 1'b0;
  logic busy, err_sync;

  bicubic_acc_sequencer_if #(.PARALLEL_CORE(N)) bus ();

  bicubic_acc_sequencer #(
    .PARALLEL_CORE(N), .BEATS_PER_PIXEL(BPP), .DSP_LATENCY(LAT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .flush(flush), .bus(bus.master),
    .busy(busy), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // DSP array: P register then two result delay stages, all on clken.
  pix_t acc, d1, d2;
  assign bus.dsp_result = d2;
  always @(posedge clk) begin
    if (bus.dsp_reset) begin
      acc <= '0; d1 <= '0; d2 <= '0;
    end else if (bus.dsp_clken) begin
      for (int l = 0; l < N; l++)
        acc[l] <= ((bus.dsp_mode == ACC_MODE_ADD) ? acc[l] : 48'd0)
                  + 48'(bus.dsp_op0[l]) + 48'(bus.dsp_op1[l]) + 48'(bus.dsp_op2[l])
                  + 48'(bus.dsp_op3[l]) + 48'(bus.dsp_cin2[l]) + 48'(bus.dsp_cin3[l]);
      d1 <= acc;
      d2 <= d1;
    end
  end

  pix_t exp_q[$];
  pix_t got_q[$];
  pix_t model_acc;
  int   model_k = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sr_wait;
  logic [3:0] mode_log;

  always @(negedge clk)
    if (aresetn && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got_q.push_back(bus.m_data);

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ops_t rnd_ops();
    ops_t r;
    for (int l = 0; l < N; l++) r[l] = DSP_OP_W'($urandom);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input bit first, input ops_t o0, o1, o2, o3,
                           input logic [N-1:0] c2, c3);
    bit ok = 0;
    int tries = 0;
    logic [47:0] bs;
    bus.s_valid = 1'b1; bus.s_first = first;
    bus.s_op0 = o0; bus.s_op1 = o1; bus.s_op2 = o2; bus.s_op3 = o3;
    bus.s_cin2 = c2; bus.s_cin3 = c3;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = bus.s_ready;
      if (ok) mode_log = {mode_log[2:0], bus.dsp_mode};
      tries++;
      @(posedge clk); #1;
    end
    if (!ok) chk("s_ready_timeout", 0, 1);
    if (tries > 1) sr_wait = 1;
    bus.s_valid = 1'b0; bus.s_first = 1'b0;
    bus.s_op0 = '0; bus.s_op1 = '0; bus.s_op2 = '0; bus.s_op3 = '0;
    bus.s_cin2 = '0; bus.s_cin3 = '0;
    if (ok) begin
      if (first) model_k = 0;
      for (int l = 0; l < N; l++) begin
        bs = 48'(o0[l]) + 48'(o1[l]) + 48'(o2[l]) + 48'(o3[l]) + 48'(c2[l]) + 48'(c3[l]);
        model_acc[l] = (model_k == 0) ? bs : model_acc[l] + bs;
      end
      model_k++;
      if (model_k == BPP) begin
        exp_q.push_back(model_acc);
        model_k = 0;
      end
    end
  endtask

  task automatic send_rand(input bit first);
    send_beat(first, rnd_ops(), rnd_ops(), rnd_ops(), rnd_ops(),
              N'($urandom), N'($urandom));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 200);
    if (busy !== 1'b0) chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic drain(input string tag);
    pix_t g, e;
    wait_idle(tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_pixel"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ops_t ones;
    pix_t e1, held;
    int   n;
    bus.s_valid = 1'b0; bus.s_first = 1'b0; bus.m_ready = 1'b1;
    bus.s_op0 = '0; bus.s_op1 = '0; bus.s_op2 = '0; bus.s_op3 = '0;
    bus.s_cin2 = '0; bus.s_cin3 = '0;
    for (int l = 0; l < N; l++) begin ones[l] = 18'd1; e1[l] = 48'd16; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_err", err_sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dsp_reset", bus.dsp_reset, 1);
    chk("rst_dsp_mode", bus.dsp_mode, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk);
    chk("rel_dsp_reset_hold", bus.dsp_reset, 1);
    @(posedge clk); #1;
    chk("rel_dsp_reset_drop", bus.dsp_reset, 0);
    chk("rel_s_ready", bus.s_ready, 1);

    // 1: all-ones pixel, LOAD/ADD/ADD/ADD, latency
    mode_log = '1;
    send_beat(1, ones, ones, ones, ones, '0, '0);
    for (int b = 1; b < BPP; b++) send_beat(0, ones, ones, ones, ones, '0, '0);
    chk("t1_modes", mode_log, 4'b0111);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.m_valid !== 1'b1 && n < 50);
    chk("t1_latency", n, LAT + 1);
    wait_idle("t1");
    chk("t1_sum", (got_q.size() > 0) ? got_q[0] : '0, e1);
    drain("t1");

    // 2: three back-to-back random pixels
    sr_wait = 0;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < BPP; b++) send_rand(b == 0);
    chk("t2_s_ready_held", sr_wait, 0);
    drain("t2");

    // 3: bubbles between beats 1 and 2
    send_rand(1); send_rand(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_bubble_ops", |{bus.dsp_op0, bus.dsp_op1, bus.dsp_op2, bus.dsp_op3,
                             bus.dsp_cin2, bus.dsp_cin3}, 0);
      chk("t3_bubble_mode", bus.dsp_mode, ACC_MODE_ADD);
    end
    @(posedge clk); #1;
    send_rand(0); send_rand(0);
    drain("t3");

    // 4: backpressure while the next group is in flight
    bus.m_ready = 1'b0;
    fork
      begin
        for (int p = 0; p < 2; p++)
          for (int b = 0; b < BPP; b++) send_rand(b == 0);
      end
      begin
        n = 0;
        while (bus.m_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("t4_valid_seen", bus.m_valid, 1);
        held = bus.m_data;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("t4_clken", bus.dsp_clken, 0);
          chk("t4_s_ready", bus.s_ready, 0);
          chk("t4_hold", bus.m_data, held);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
      end
    join
    drain("t4");

    // 5: s_first mid-group aborts the partial group
    send_rand(1); send_rand(0);
    send_rand(1);
    for (int b = 1; b < BPP; b++) send_rand(0);
    chk("t5_err_set", err_sync, 1);
    drain("t5");
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_s_ready", bus.s_ready, 0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", err_sync, 0);
    chk("t5_dsp_reset", bus.dsp_reset, 1);
    @(posedge clk); #1;
    chk("t5_dsp_reset_drop", bus.dsp_reset, 0);

    // 6: reset mid-group, then flush mid-flight
    send_rand(1); send_rand(0);
    aresetn = 1'b0; #1;
    chk("t6_rst_m_valid", bus.m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_dsp_reset", bus.dsp_reset, 1);
    model_k = 0;
    @(posedge clk); #1; aresetn = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_release", bus.dsp_reset, 0);
    for (int b = 0; b < BPP; b++) send_rand(b == 0);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    void'(exp_q.pop_back());
    model_k = 0;
    chk("t6_flush_busy", busy, 0);
    chk("t6_flush_dsp_reset", bus.dsp_reset, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0) n++;
    end
    chk("t6_no_partial_out", n, 0);
    chk("t6_no_output", got_q.size(), 0);
    @(posedge clk); #1;
    for (int b = 0; b < BPP; b++) send_rand(b == 0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
